// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the PPU frame-buffer write controller:
//   - frame geometry (FB_W x FB_H) and write FIFO depth
//   - colour_code_t : 6-bit NES palette index
//   - fb_pix_t      : one queued pixel write {x, y, code}
//   - fb_state_t    : controller states (IDLE / CLEAR)
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_W          = 256;
    localparam int FB_H          = 240;
    localparam int FB_FIFO_DEPTH = 4;
    localparam int FB_FIFO_AW    = 2;

    typedef logic [5:0] colour_code_t;

    typedef struct packed {
        logic [7:0]   x;
        logic [7:0]   y;
        colour_code_t code;
    } fb_pix_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// ---------------------------------------------------------------------------
// fb_wr_fifo
// Synchronous 4-entry show-ahead FIFO holding pending pixel writes.
// The head entry is always visible on rd_data_o; pop_i advances it.
// A push and a pop may happen in the same cycle, giving 1 entry/cycle.
//
// Ports:
//   clk_i      clock (rising edge)
//   rst_i      asynchronous active-high reset, empties the FIFO
//   push_i     write wr_data_i into the tail (ignored when full without pop)
//   wr_data_i  packed fb_pix_t to enqueue
//   pop_i      drop the head entry (ignored when empty)
//   rd_data_o  current head entry
//   full_o     all entries occupied (from registered count)
//   empty_o    no entries (from registered count)
// ---------------------------------------------------------------------------
module fb_wr_fifo
    import fb_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic [$bits(fb_pix_t)-1:0]  wr_data_i,
    input  logic                        pop_i,
    output logic [$bits(fb_pix_t)-1:0]  rd_data_o,
    output logic                        full_o,
    output logic                        empty_o
);

    fb_pix_t                 mem_q [FB_FIFO_DEPTH];
    logic [FB_FIFO_AW-1:0]   wr_ptr_q;
    logic [FB_FIFO_AW-1:0]   rd_ptr_q;
    logic [FB_FIFO_AW:0]     count_q;
    logic                    do_push;
    logic                    do_pop;

    assign full_o    = (count_q == (FB_FIFO_AW+1)'(FB_FIFO_DEPTH));
    assign empty_o   = (count_q == '0);
    assign rd_data_o = mem_q[rd_ptr_q];

    // A full FIFO can still accept a push when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FB_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= fb_pix_t'(wr_data_i);
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {{FB_FIFO_AW{1'b0}}, do_push}
                               - {{FB_FIFO_AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/fb_wr_ctl.sv
// ---------------------------------------------------------------------------
// fb_wr_ctl
// Frame-buffer write controller for the PPU. Pixel writes are queued in a
// 4-entry FIFO and drained one per cycle onto a registered frame-buffer
// write port. A clear request fills the whole 256x240 frame with one colour
// once all earlier queued pixels have been written.
//
// Optional feature (define FB_WR_BOUNDS_CHK_EN): accepted pixels with
// pix_y beyond the last row are dropped and set the sticky oob_err flag.
// Without it, such pixels are written as-is and oob_err is tied low.
//
// Ports:
//   ppu_ctl_clk  clock (rising edge)
//   reset        asynchronous active-high reset
//   pix_valid    pixel write request; accepted when pix_ready is also high
//   pix_x/pix_y  pixel column / row
//   pix_code     NES colour code for the pixel
//   pix_ready    controller can accept a pixel this cycle
//   clr_start    one-cycle request for a full-frame clear
//   clr_code     fill colour, sampled with clr_start
//   fb_x/fb_y    registered frame-buffer write address
//   fb_di        registered frame-buffer write data
//   fb_cs        write strobe, one write per high cycle
//   busy         FIFO non-empty, clear pending or clear running
//   clr_done     pulses with the final clear write
//   oob_err      sticky out-of-range pixel flag
// ---------------------------------------------------------------------------
module fb_wr_ctl
    import fb_pkg::*;
(
    input  logic       ppu_ctl_clk,
    input  logic       reset,
    input  logic       pix_valid,
    input  logic [7:0] pix_x,
    input  logic [7:0] pix_y,
    input  logic [5:0] pix_code,
    output logic       pix_ready,
    input  logic       clr_start,
    input  logic [5:0] clr_code,
    output logic [7:0] fb_x,
    output logic [7:0] fb_y,
    output logic [5:0] fb_di,
    output logic       fb_cs,
    output logic       busy,
    output logic       clr_done,
    output logic       oob_err
);

    fb_state_t    state_q, state_d;
    logic         clr_pend_q, clr_pend_d;
    colour_code_t clr_code_q, clr_code_d;
    logic [7:0]   cx_q, cx_d;
    logic [7:0]   cy_q, cy_d;
    logic [7:0]   fb_x_q, fb_x_d;
    logic [7:0]   fb_y_q, fb_y_d;
    colour_code_t fb_di_q, fb_di_d;
    logic         fb_cs_q, fb_cs_d;
    logic         clr_done_q, clr_done_d;
    logic         rdy_en_q;

    logic         accept;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    fb_pix_t      head;
    fb_pix_t      in_pix;

    assign in_pix = '{x: pix_x, y: pix_y, code: pix_code};

    // rdy_en_q holds pix_ready low through reset and releases it on the
    // first clock edge afterwards; everything else here is registered too.
    assign pix_ready = rdy_en_q && !fifo_full && !clr_pend_q && (state_q == ST_IDLE);
    assign accept    = pix_valid && pix_ready;
    assign busy      = !fifo_empty || clr_pend_q || (state_q == ST_CLEAR);

    assign fb_x     = fb_x_q;
    assign fb_y     = fb_y_q;
    assign fb_di    = fb_di_q;
    assign fb_cs    = fb_cs_q;
    assign clr_done = clr_done_q;

`ifdef FB_WR_BOUNDS_CHK_EN
    logic oob_q;

    // Rows past the bottom of the frame never reach the FIFO.
    assign push    = accept && (pix_y < 8'(FB_H));
    assign oob_err = oob_q;

    always_ff @(posedge ppu_ctl_clk or posedge reset) begin
        if (reset) begin
            oob_q <= 1'b0;
        end else if (accept && (pix_y >= 8'(FB_H))) begin
            oob_q <= 1'b1;
        end
    end
`else
    assign push    = accept;
    assign oob_err = 1'b0;
`endif

    fb_wr_fifo u_fifo (
        .clk_i     (ppu_ctl_clk),
        .rst_i     (reset),
        .push_i    (push),
        .wr_data_i (in_pix),
        .pop_i     (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Next-state logic. Queued pixels always drain before a pending clear
    // starts, so a pixel accepted alongside clr_start lands ahead of the
    // fill. New clear requests are dropped while one is pending or running.
    always_comb begin
        state_d    = state_q;
        clr_pend_d = clr_pend_q;
        clr_code_d = clr_code_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        fb_x_d     = fb_x_q;
        fb_y_d     = fb_y_q;
        fb_di_d    = fb_di_q;
        fb_cs_d    = 1'b0;
        clr_done_d = 1'b0;
        pop        = 1'b0;

        if (clr_start && !clr_pend_q && (state_q != ST_CLEAR)) begin
            clr_pend_d = 1'b1;
            clr_code_d = clr_code;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    fb_x_d  = head.x;
                    fb_y_d  = head.y;
                    fb_di_d = head.code;
                    fb_cs_d = 1'b1;
                end else if (clr_pend_q) begin
                    state_d    = ST_CLEAR;
                    clr_pend_d = 1'b0;
                    cx_d       = '0;
                    cy_d       = '0;
                end
            end
            ST_CLEAR: begin
                fb_x_d  = cx_q;
                fb_y_d  = cy_q;
                fb_di_d = clr_code_q;
                fb_cs_d = 1'b1;
                if (cx_q == 8'(FB_W - 1)) begin
                    cx_d = '0;
                    if (cy_q == 8'(FB_H - 1)) begin
                        state_d    = ST_IDLE;
                        clr_done_d = 1'b1;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge ppu_ctl_clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clr_pend_q <= 1'b0;
            clr_code_q <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            fb_x_q     <= '0;
            fb_y_q     <= '0;
            fb_di_q    <= '0;
            fb_cs_q    <= 1'b0;
            clr_done_q <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_pend_q <= clr_pend_d;
            clr_code_q <= clr_code_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            fb_x_q     <= fb_x_d;
            fb_y_q     <= fb_y_d;
            fb_di_q    <= fb_di_d;
            fb_cs_q    <= fb_cs_d;
            clr_done_q <= clr_done_d;
            rdy_en_q   <= 1'b1;
        end
    end

endmodule

// File: doc/fb_wr_ctl.md
FB_WR_CTL -- requirements
Module: fb_wr_ctl

Interface
REQ-001 ppu_ctl_clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 pix_valid  in  1  PPU pixel write request.
REQ-004 pix_x  in  8  pixel column, 0..255.
REQ-005 pix_y  in  8  pixel row, 0..239 legal.
REQ-006 pix_code  in  6  NES colour code.
REQ-007 pix_ready  out  1  pixel accepted when pix_valid && pix_ready.
REQ-008 clr_start  in  1  single-cycle pulse requesting a full-frame clear.
REQ-009 clr_code  in  6  fill colour code, sampled on the cycle clr_start is high.
REQ-010 fb_x, fb_y  out  8 each  frame-buffer write address, registered.
REQ-011 fb_di  out  6  frame-buffer write data, registered.
REQ-012 fb_cs  out  1  frame-buffer write strobe; one write per high cycle.
REQ-013 busy  out  1  high while the FIFO is non-empty, a clear is pending, or a clear is running.
REQ-014 clr_done  out  1  one-cycle pulse after the last clear write.
REQ-015 oob_err  out  1  sticky out-of-range flag (see REQ-029).

Function
REQ-016 Accepted pixels SHALL enter a 4-entry FIFO {x,y,code}; pix_ready SHALL equal !full && !clr_pend && state==IDLE, computed from registered state only.
REQ-017 In IDLE with the FIFO non-empty, the head entry SHALL be popped each cycle and driven on fb_x/fb_y/fb_di with fb_cs=1 on the next cycle.
REQ-018 Latency from acceptance into an empty FIFO to fb_cs=1 SHALL be exactly 2 cycles; sustained throughput SHALL be 1 pixel/cycle.
REQ-019 Write order SHALL equal acceptance order.
REQ-020 clr_start SHALL set clr_pend and latch clr_code; a pixel accepted in the same cycle SHALL be written before the clear.
REQ-021 States SHALL be IDLE and CLEAR; IDLE->CLEAR when clr_pend && FIFO empty, clearing clr_pend.
REQ-022 CLEAR SHALL issue one write per cycle, x incrementing 0..255 within each row and y 0..239, for 61440 writes with fb_di=latched code.
REQ-023 After the write at (255,239), the state SHALL return to IDLE, with clr_done pulsed in the cycle that write is presented on fb_cs.
REQ-024 clr_start while clr_pend or CLEAR is set SHALL be ignored, including its clr_code.
REQ-025 While CLEAR is active, pix_ready SHALL be 0 and FIFO contents SHALL be held.
REQ-026 fb_cs SHALL be 0 in any cycle with no pop and no clear write; fb_x/fb_y/fb_di SHALL hold their last values when fb_cs=0.

Reset
REQ-027 On reset assertion, at any point including mid-clear, the block SHALL immediately enter IDLE; empty the FIFO; clear clr_pend and oob_err; and drive fb_cs=0, clr_done=0, fb_x=fb_y=0, fb_di=0, busy=0 and pix_ready=0.
REQ-028 pix_ready SHALL rise on the first clock edge after reset deasserts.

Configuration
REQ-029 With FB_WR_BOUNDS_CHK_EN defined, an accepted pixel with pix_y>239 SHALL be discarded without entering the FIFO and SHALL set oob_err until reset.
REQ-030 Without FB_WR_BOUNDS_CHK_EN, such pixels SHALL be written unchanged and oob_err SHALL be tied to 0.

Structure
REQ-031 Package fb_pkg SHALL hold FB_W=256, FB_H=240, FB_FIFO_DEPTH=4, typedef colour_code_t (6-bit), typedef fb_pix_t {x,y,code}, and the state enum.
REQ-032 The FIFO SHALL be a sub-module, fb_wr_fifo (synchronous, 4-entry, full/empty flags, same clock and reset).

Verification
REQ-033 Single pixel (10,20,0x16) into an idle, empty block -> fb_cs=1 two cycles later with fb_x=10, fb_y=20, fb_di=0x16.
REQ-034 Five back-to-back pixels -> pix_ready drops only when the FIFO is full, and five in-order writes occur with fb_cs high for five consecutive cycles.
REQ-035 clr_start (code 0x0F) with 3 pixels queued -> the 3 pixels are written first, then 61440 writes ending at (255,239), with clr_done pulsing exactly once.
REQ-036 clr_start pulsed again at clear write 1000 -> ignored; the total write count stays 61440 and fb_di stays 0x0F.
REQ-037 Reset asserted at clear write 30000 -> fb_cs falls immediately; after release the block is IDLE, with pix_ready=1 one edge later.
REQ-038 Pixel with y=250 -> with FB_WR_BOUNDS_CHK_EN, no write occurs and oob_err=1; without it, a write occurs at y=250 and oob_err=0.
